// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch state encoding, the NOP word and the architectural reset PC.
package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DROP  = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR_C    = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR_C = 32'h0040_0000;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_ifid_reg.sv
// IF/ID pipeline register: load a new entry, hold it, or clear it to an invalid NOP.
// Clear takes priority over load.
module inst_fetch_unit_ifid_reg
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] in_pc_plus4,
    input  logic [31:0] in_instr,
    input  logic        in_adel,
    output logic        valid,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] instr,
    output logic        adel
);

    logic        valid_q, valid_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] instr_q, instr_d;
    logic        adel_q, adel_d;

    // Next-entry selection: clear, load or hold.
    always_comb begin
        valid_d = valid_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        adel_d  = adel_q;
        if (clear) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            adel_d  = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc4_d   = in_pc_plus4;
            instr_d = in_instr;
            adel_d  = in_adel;
        end else begin
            valid_d = valid_q;
        end
    end

    // Register state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc4_q   <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
            adel_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            adel_q  <= adel_d;
        end
    end

    assign valid        = valid_q;
    assign pc_plus4_out = pc4_q;
    assign instr        = instr_q;
    assign adel         = adel_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// IF stage: fetches the instruction at pc_in over a variable-latency handshake and
// fills IF/ID, absorbing ID stalls (HOLD buffer) and flushes (DROP of an unfinished request).
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        pc_advance,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        ifid_adel
);

    state_e      state_q, state_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] buf_instr_q, buf_instr_d;

    logic        ld_s, clr_s, ld_adel_s;
    logic [31:0] ld_pc4_s, ld_instr_s;

    // Fetch control: request generation, PC advance and IF/ID load/clear decisions.
    always_comb begin
        state_d     = state_q;
        drop_addr_d = drop_addr_q;
        buf_pc4_d   = buf_pc4_q;
        buf_instr_d = buf_instr_q;
        imem_req    = 1'b0;
        imem_addr   = pc_in;
        pc_advance  = 1'b0;
        ld_s        = 1'b0;
        clr_s       = 1'b0;
        ld_pc4_s    = pc_plus4(pc_in);
        ld_instr_s  = imem_rdata;
        ld_adel_s   = 1'b0;
        if (!rst_n) begin
            state_d     = ST_FETCH;
            drop_addr_d = 32'h0000_0000;
            buf_pc4_d   = 32'h0000_0000;
            buf_instr_d = NOP_INSTR;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (pc_in[1:0] == 2'b00) begin
                        imem_req = 1'b1;
                        if (flush) begin
                            clr_s = 1'b1;
                            if (imem_ready) begin
                                state_d = ST_FETCH;
                            end else begin
                                drop_addr_d = pc_in;
                                state_d     = ST_DROP;
                            end
                        end else if (imem_ready && stall) begin
                            buf_pc4_d   = pc_plus4(pc_in);
                            buf_instr_d = imem_rdata;
                            state_d     = ST_HOLD;
                        end else if (imem_ready) begin
                            ld_s       = 1'b1;
                            pc_advance = 1'b1;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else begin
                        // Misaligned PC completes immediately as a NOP tagged with adel.
                        ld_instr_s = NOP_INSTR;
                        ld_adel_s  = 1'b1;
                        if (flush) begin
                            clr_s = 1'b1;
                        end else if (!stall) begin
                            ld_s       = 1'b1;
                            pc_advance = 1'b1;
                        end else begin
                            ld_s = 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    imem_req  = 1'b1;
                    imem_addr = drop_addr_q;
                    clr_s     = flush;
                    if (imem_ready) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                ST_HOLD: begin
                    ld_pc4_s   = buf_pc4_q;
                    ld_instr_s = buf_instr_q;
                    if (flush) begin
                        clr_s   = 1'b1;
                        state_d = ST_FETCH;
                    end else if (!stall) begin
                        ld_s       = 1'b1;
                        pc_advance = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // State, drop address and stall buffer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            drop_addr_q <= 32'h0000_0000;
            buf_pc4_q   <= 32'h0000_0000;
            buf_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            drop_addr_q <= drop_addr_d;
            buf_pc4_q   <= buf_pc4_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    inst_fetch_unit_ifid_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ld_s),
        .clear       (clr_s),
        .in_pc_plus4 (ld_pc4_s),
        .in_instr    (ld_instr_s),
        .in_adel     (ld_adel_s),
        .valid       (ifid_valid),
        .pc_plus4_out(ifid_pc_plus4),
        .instr       (ifid_instr),
        .adel        (ifid_adel)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: acts as PC register and instruction memory, predicts every
// cycle from a transaction-level model, with directed scenarios followed by random traffic.
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, flush, imem_ready;
    logic [31:0] pc_in, imem_rdata;
    wire         imem_req, pc_advance, ifid_valid, ifid_adel;
    wire  [31:0] imem_addr, ifid_pc_plus4, ifid_instr;

    inst_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .stall(stall), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .pc_advance(pc_advance), .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_instr(ifid_instr), .ifid_valid(ifid_valid), .ifid_adel(ifid_adel)
    );

    int vectors = 0;
    int miscompares = 0;

    // Environment: PC register and memory with a per-request latency.
    logic [31:0] pc = RESET_VECTOR_C;
    bit          mem_busy = 1'b0;
    int          mem_wait = 0;
    int          lat_sel = 0;
    bit          force_rd = 1'b0;
    logic [31:0] rd_val = 32'h0;

    // Model: IF/ID contents, a parked word behind a stall, a cancelled request in flight.
    bit          m_ifv = 1'b0, m_ifa = 1'b0;
    logic [31:0] m_ifi = 32'h0, m_ifp = 32'h0;
    bit          m_buf_v = 1'b0;
    logic [31:0] m_buf_i = 32'h0, m_buf_p = 32'h0;
    bit          m_drop = 1'b0;
    logic [31:0] m_drop_a = 32'h0;

    logic        got_req, got_adv;
    logic [31:0] got_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit f, input logic [31:0] redir);
        int          mode;
        bit          rdy, e_req, e_adv;
        logic [31:0] e_addr, rd;
        @(negedge clk);
        rst_n = r; stall = s; flush = f; pc_in = pc;
        if (!r)               mode = 0;
        else if (m_buf_v)     mode = 1;
        else if (m_drop)      mode = 2;
        else if (pc[1:0] == 2'b00) mode = 3;
        else                  mode = 4;
        e_req  = (mode == 2) || (mode == 3);
        e_addr = (mode == 2) ? m_drop_a : pc;
        e_adv  = 1'b0;
        if (e_req && !mem_busy) begin
            mem_busy = 1'b1;
            mem_wait = (lat_sel < 0) ? int'($urandom_range(3, 0)) : lat_sel;
        end
        rdy = e_req && mem_busy && (mem_wait == 0);
        rd  = force_rd ? rd_val : $urandom;
        imem_ready = rdy; imem_rdata = rd;
        case (mode)
            0: begin
                m_ifv = 1'b0; m_ifi = NOP_INSTR_C; m_ifp = 32'h0; m_ifa = 1'b0;
                m_buf_v = 1'b0; m_drop = 1'b0;
            end
            1: begin
                if (f) begin
                    m_buf_v = 1'b0; m_ifv = 1'b0; m_ifi = NOP_INSTR_C;
                end else if (!s) begin
                    m_ifv = 1'b1; m_ifi = m_buf_i; m_ifp = m_buf_p; m_ifa = 1'b0;
                    m_buf_v = 1'b0; e_adv = 1'b1;
                end
            end
            2: begin
                if (f) begin m_ifv = 1'b0; m_ifi = NOP_INSTR_C; end
                if (rdy) m_drop = 1'b0;
            end
            3: begin
                if (f) begin
                    m_ifv = 1'b0; m_ifi = NOP_INSTR_C;
                    if (!rdy) begin m_drop = 1'b1; m_drop_a = pc; end
                end else if (rdy && s) begin
                    m_buf_v = 1'b1; m_buf_i = rd; m_buf_p = pc + 32'd4;
                end else if (rdy) begin
                    m_ifv = 1'b1; m_ifi = rd; m_ifp = pc + 32'd4; m_ifa = 1'b0; e_adv = 1'b1;
                end
            end
            default: begin
                if (f) begin
                    m_ifv = 1'b0; m_ifi = NOP_INSTR_C;
                end else if (!s) begin
                    m_ifv = 1'b1; m_ifi = NOP_INSTR_C; m_ifp = pc + 32'd4; m_ifa = 1'b1;
                    e_adv = 1'b1;
                end
            end
        endcase
        #1;
        got_req = imem_req; got_addr = imem_addr; got_adv = pc_advance;
        chk("imem_req", {31'h0, got_req}, {31'h0, e_req});
        if (e_req) chk("imem_addr", got_addr, e_addr);
        chk("pc_advance", {31'h0, got_adv}, {31'h0, e_adv});
        @(posedge clk);
        if (!r || rdy) mem_busy = 1'b0;
        else if (mem_busy) mem_wait--;
        if (!r)         pc = RESET_VECTOR_C;
        else if (f)     pc = redir;
        else if (e_adv) pc = pc + 32'd4;
        #1;
        chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_ifv});
        chk("ifid_instr", ifid_instr, m_ifi);
        if (m_ifv) begin
            chk("ifid_pc_plus4", ifid_pc_plus4, m_ifp);
            chk("ifid_adel", {31'h0, ifid_adel}, {31'h0, m_ifa});
        end
    endtask

    initial begin
        logic [31:0] rv;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; pc_in = RESET_VECTOR_C;
        imem_ready = 1'b0; imem_rdata = 32'h0;

        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        chk("pin_reset_valid", {31'h0, ifid_valid}, 32'h0);
        chk("pin_reset_instr", ifid_instr, 32'h0000_0000);

        // Zero-wait memory: one instruction per cycle.
        lat_sel = 0;
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 0, 32'h0);
            chk("pin_seq_pc4", ifid_pc_plus4, 32'h0040_0000 + 32'(4 * k));
            chk("pin_seq_adv", {31'h0, got_adv}, 32'h1);
        end

        // Flush during a 3-cycle fetch of 0x00400010, redirect to 0x80000004.
        lat_sel = 3;
        step(1, 0, 1, 32'h8000_0004);
        chk("pin_flush_addr", got_addr, 32'h0040_0010);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 32'h0);
            chk("pin_drop_addr", got_addr, 32'h0040_0010);
        end
        chk("pin_drop_valid", {31'h0, ifid_valid}, 32'h0);

        // 3-cycle latency fetch.
        force_rd = 1'b1; rd_val = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 32'h0);
            chk("pin_lat_req", {31'h0, got_req}, 32'h1);
            chk("pin_lat_addr", got_addr, 32'h8000_0004);
            chk("pin_lat_adv", {31'h0, got_adv}, 32'h0);
        end
        step(1, 0, 0, 32'h0);
        chk("pin_lat_done_adv", {31'h0, got_adv}, 32'h1);
        chk("pin_lat_instr", ifid_instr, 32'h1234_5678);
        chk("pin_lat_pc4", ifid_pc_plus4, 32'h8000_0008);

        // Stall on the ready cycle, released two cycles later.
        lat_sel = 0; rd_val = 32'h8C08_0000;
        step(1, 1, 0, 32'h0);
        chk("pin_stall_adv", {31'h0, got_adv}, 32'h0);
        chk("pin_stall_instr", ifid_instr, 32'h1234_5678);
        step(1, 1, 0, 32'h0);
        chk("pin_hold_req", {31'h0, got_req}, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("pin_release_adv", {31'h0, got_adv}, 32'h1);
        chk("pin_release_instr", ifid_instr, 32'h8C08_0000);
        lat_sel = 2;
        step(1, 0, 0, 32'h0);
        chk("pin_release_once", {31'h0, got_adv}, 32'h0);

        // Misaligned fetch.
        step(1, 0, 1, 32'h0040_0002);
        for (int k = 0; k < 8 && m_drop; k++) step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("pin_mis_req", {31'h0, got_req}, 32'h0);
        chk("pin_mis_adel", {31'h0, ifid_adel}, 32'h1);
        chk("pin_mis_pc4", ifid_pc_plus4, 32'h0040_0006);
        chk("pin_mis_instr", ifid_instr, 32'h0000_0000);

        // PC+4 wraps at the top of the address space.
        step(1, 0, 1, 32'hFFFF_FFFC);
        lat_sel = 0;
        step(1, 0, 0, 32'h0);
        chk("pin_wrap_pc4", ifid_pc_plus4, 32'h0000_0000);

        // Reset while holding, then while dropping.
        step(1, 1, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        chk("pin_rst_hold_valid", {31'h0, ifid_valid}, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("pin_rst_hold_addr", got_addr, 32'h0040_0000);
        lat_sel = 3;
        step(1, 0, 1, 32'h0000_0100);
        step(0, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("pin_rst_drop_req", {31'h0, got_req}, 32'h1);
        chk("pin_rst_drop_addr", got_addr, 32'h0040_0000);

        // Random traffic.
        lat_sel = -1; force_rd = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit r, s, f;
            r  = ($urandom_range(199, 0) != 0);
            s  = ($urandom_range(3, 0) == 0);
            f  = ($urandom_range(9, 0) == 0);
            rv = $urandom;
            rv[1:0] = ($urandom_range(7, 0) == 0) ? 2'b10 : 2'b00;
            step(r, s, f, rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
